// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types and 7-segment decoding for the run/step debug controller.
package dbg_pkg;
    typedef enum logic [1:0] {HALT, STEP, RUN} run_state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    function automatic logic [6:0] hex7seg(input logic [3:0] h);
        return SEG_LUT[h];
    endfunction
endpackage

// File: rtl/dbg_ctrl_if.sv
// dbg_ctrl_if: board I/O and CPU-side signals of the debug controller.
interface dbg_ctrl_if #(parameter int ADDR_W = 8, NCH = 8, DIGITS = 8);
    localparam int SEL_W = $clog2(NCH);
    logic                succ, step, inc, dec, m_rf;
    logic [SEL_W-1:0]    sel;
    logic [31:0]         mrf_data;
    logic [NCH*32-1:0]   status;
    logic                cpu_en, halted;
    logic [ADDR_W-1:0]   m_rf_addr;
    logic [31:0]         step_cnt;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    modport master (
        output succ, step, inc, dec, m_rf, sel, mrf_data, status,
        input  cpu_en, halted, m_rf_addr, step_cnt, seg, an
    );
    modport slave (
        input  succ, step, inc, dec, m_rf, sel, mrf_data, status,
        output cpu_en, halted, m_rf_addr, step_cnt, seg, an
    );
endinterface

// File: rtl/dbg_btn.sv
// dbg_btn: button conditioning; 2-FF sync, stable-level debounce, rising-edge pulse.
module dbg_btn #(parameter int DEB_CYC = 100000) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic p
);
    localparam int CW = DEB_CYC > 1 ? $clog2(DEB_CYC) : 1;
    logic s1, s2, deb, deb_d;
    logic [CW-1:0] cnt;
    // cnt counts consecutive synced samples that disagree with the accepted level
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            deb <= 1'b0;
            deb_d <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            deb_d <= deb;
            if (s2 == deb) cnt <= '0;
            else if (cnt == CW'(DEB_CYC - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else cnt <= cnt + CW'(1);
        end
    assign p = deb & ~deb_d;
endmodule

// File: rtl/dbg_ctrl.sv
// dbg_ctrl: run/step CPU gating, address browsing and multiplexed 7-segment display.
module dbg_ctrl import dbg_pkg::*; #(
    parameter int ADDR_W   = 8,
    parameter int NCH      = 8,
    parameter int DIGITS   = 8,
    parameter int DEB_CYC  = 100000,
    parameter int SCAN_DIV = 30000
) (
    input logic clk,
    input logic rst,
    dbg_ctrl_if.slave bus
);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    logic step_p, inc_p, dec_p, mrf_d, cpu_en, halted;
    logic [1:0] succ_s, mrf_s;
    run_state_t state;
    logic [ADDR_W-1:0] addr;
    logic [31:0] cnt, word;
    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] digit;
    logic [DIGITS-1:0] an;
    logic [6:0] seg;
    logic [3:0] nib;
    logic blank;
    dbg_btn #(.DEB_CYC(DEB_CYC)) u_step (.clk(clk), .rst(rst), .btn(bus.step), .p(step_p));
    dbg_btn #(.DEB_CYC(DEB_CYC)) u_inc  (.clk(clk), .rst(rst), .btn(bus.inc),  .p(inc_p));
    dbg_btn #(.DEB_CYC(DEB_CYC)) u_dec  (.clk(clk), .rst(rst), .btn(bus.dec),  .p(dec_p));
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            succ_s <= '0;
            mrf_s <= '0;
            mrf_d <= 1'b0;
        end else begin
            succ_s <= {succ_s[0], bus.succ};
            mrf_s <= {mrf_s[0], bus.m_rf};
            mrf_d <= mrf_s[1];
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= HALT;
            cpu_en <= 1'b0;
            halted <= 1'b1;
        end else begin
            unique case (state)
                HALT: if (succ_s[1] || step_p) begin
                    state <= succ_s[1] ? RUN : STEP;
                    cpu_en <= 1'b1;
                    halted <= 1'b0;
                end
                RUN: if (!succ_s[1]) begin
                    state <= HALT;
                    cpu_en <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state <= HALT;
                    cpu_en <= 1'b0;
                    halted <= 1'b1;
                end
            endcase
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else cnt <= cnt + 32'(cpu_en);
    // a browse-target switch invalidates the old address, so it beats inc/dec
    always_ff @(posedge clk or negedge rst)
        if (!rst) addr <= '0;
        else if (mrf_s[1] != mrf_d) addr <= '0;
        else if (bus.sel == '0 && (inc_p ^ dec_p)) addr <= inc_p ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
    always_comb begin
        word = bus.sel == '0 ? bus.mrf_data : int'(bus.sel) < NCH ? bus.status[32*int'(bus.sel) +: 32] : 32'h0;
        nib = 4'(word >> (4 * int'(digit)));
        blank = int'(digit) > 7;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            scan_cnt <= '0;
            digit <= '0;
            an <= '1;
            seg <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_cnt == SW'(SCAN_DIV - 1) ? '0 : scan_cnt + SW'(1);
            if (scan_cnt == SW'(SCAN_DIV - 1)) digit <= digit == DW'(DIGITS - 1) ? '0 : digit + DW'(1);
            an <= ~(DIGITS'(1) << digit);
            seg <= blank ? SEG_BLANK : hex7seg(nib);
        end
    assign bus.cpu_en = cpu_en;
    assign bus.halted = halted;
    assign bus.m_rf_addr = addr;
    assign bus.step_cnt = cnt;
    assign bus.an = an;
    assign bus.seg = seg;
endmodule

// File: tb/tb_dbg_ctrl.sv
// tb_dbg_ctrl: randomized and directed checks of dbg_ctrl against a behavioural model.
module tb_dbg_ctrl;
    localparam int DEB = 4, SD = 3, ND = 8, AW = 4;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic clk = 1'b0, rst = 1'b0;
    logic succ = 1'b0, step = 1'b0, inc = 1'b0, dec = 1'b0, m_rf = 1'b0;
    logic [2:0] sel = '0;
    logic [31:0] mrf_data = '0;
    logic [255:0] status = '0;
    int compared = 0, mismatched = 0;
    logic [4:0] hist[$];

    dbg_ctrl_if #(.ADDR_W(AW), .NCH(8), .DIGITS(ND)) b8 ();
    dbg_ctrl_if #(.ADDR_W(AW), .NCH(6), .DIGITS(ND)) b6 ();
    dbg_ctrl #(.ADDR_W(AW), .NCH(8), .DIGITS(ND), .DEB_CYC(DEB), .SCAN_DIV(SD)) dut (.clk(clk), .rst(rst), .bus(b8));
    dbg_ctrl #(.ADDR_W(AW), .NCH(6), .DIGITS(ND), .DEB_CYC(DEB), .SCAN_DIV(SD)) dut6 (.clk(clk), .rst(rst), .bus(b6));

    assign {b8.succ, b8.step, b8.inc, b8.dec, b8.m_rf, b8.sel} = {succ, step, inc, dec, m_rf, sel};
    assign {b6.succ, b6.step, b6.inc, b6.dec, b6.m_rf, b6.sel} = {succ, step, inc, dec, m_rf, sel};
    assign b8.mrf_data = mrf_data;
    assign b6.mrf_data = mrf_data;
    assign b8.status = status;
    assign b6.status = status[191:0];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic i, input logic d, input logic s);
        {inc, dec, step} = {i, d, s};
        cyc(8);
        {inc, dec, step} = 3'b000;
        cyc(8);
    endtask

    function automatic logic [31:0] word(input int nch);
        if (sel == 0) return mrf_data;
        if (int'(sel) < nch) return status[32*int'(sel) +: 32];
        return 32'h0;
    endfunction

    // raw input bit b as sampled at edge k after reset release (0 before release)
    function automatic logic raw(input int k, input int b);
        if (k < 1) return 1'b0;
        return hist[k-1][b];
    endfunction

    // model: buttons/succ/m_rf seen through 2 sync stages, debounce = DEB equal samples
    initial begin
        int n, nst, mst, dig;
        logic mdeb[3], mpul[3];
        logic men, mhalt, v, same;
        logic [31:0] mcnt, w8, w6;
        logic [AW-1:0] maddr;
        logic [7:0] an_exp;
        n = 0; mst = 0; men = 0; mhalt = 1; mcnt = 0; maddr = 0;
        mdeb = '{0, 0, 0}; mpul = '{0, 0, 0};
        forever begin
            @(posedge clk);
            if (!rst) begin
                hist.delete();
                n = 0; mst = 0; men = 0; mhalt = 1; mcnt = 0; maddr = 0;
                mdeb = '{0, 0, 0}; mpul = '{0, 0, 0};
                #1;
                chk("rst_cpu_en", 32'(b8.cpu_en), 0);
                chk("rst_halted", 32'(b8.halted), 1);
                chk("rst_step_cnt", b8.step_cnt, 0);
                chk("rst_addr", 32'(b8.m_rf_addr), 0);
                chk("rst_an", 32'(b8.an), 32'hFF);
                chk("rst_seg", 32'(b8.seg), 32'h7F);
                continue;
            end
            n++;
            hist.push_back({m_rf, succ, dec, inc, step});
            w8 = word(8);
            w6 = word(6);
            nst = mst == 0 ? (raw(n-2, 3) ? 2 : mpul[0] ? 1 : 0) : mst == 1 ? 0 : (raw(n-2, 3) ? 2 : 0);
            mcnt = mcnt + 32'(men);
            mst = nst;
            men = nst != 0;
            mhalt = nst == 0;
            if (raw(n-2, 4) != raw(n-3, 4)) maddr = 0;
            else if (sel == 0 && mpul[1] != mpul[2]) maddr = mpul[1] ? maddr + 1'b1 : maddr - 1'b1;
            for (int b = 0; b < 3; b++) begin
                v = raw(n-2, b);
                same = 1;
                for (int k = n-1-DEB; k <= n-2; k++) if (raw(k, b) != v) same = 0;
                mpul[b] = 0;
                if (same && v != mdeb[b]) begin
                    mdeb[b] = v;
                    mpul[b] = v;
                end
            end
            dig = ((n - 1) / SD) % ND;
            an_exp = ~(8'h01 << dig);
            #1;
            chk("cpu_en", 32'(b8.cpu_en), 32'(men));
            chk("halted", 32'(b8.halted), 32'(mhalt));
            chk("step_cnt", b8.step_cnt, mcnt);
            chk("addr", 32'(b8.m_rf_addr), 32'(maddr));
            chk("an", 32'(b8.an), 32'(an_exp));
            chk("seg", 32'(b8.seg), 32'(HEX[4'(w8 >> (4*dig))]));
            chk("an6", 32'(b6.an), 32'(an_exp));
            chk("seg6", 32'(b6.seg), 32'(HEX[4'(w6 >> (4*dig))]));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones, at, found;
        logic [31:0] c0;
        logic [6:0] exp_seg [8];
        exp_seg = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        cyc(3);
        rst = 1'b1;
        cyc(2);
        // bounce: short highs never accepted, then one clean press
        for (int i = 0; i < 10; i++) begin
            step = (i % 2 == 0);
            cyc(2);
        end
        step = 1'b1;
        ones = 0; at = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (b8.cpu_en) begin
                ones++;
                at = i;
            end
        end
        chk("bounce_ones", ones, 1);
        chk("bounce_at", at, 7);
        chk("bounce_cnt", b8.step_cnt, 1);
        step = 1'b0;
        cyc(10);
        // run/halt with an ignored step press
        c0 = b8.step_cnt;
        succ = 1'b1;
        step = 1'b1;
        ones = 0;
        for (int i = 1; i <= 24; i++) begin
            cyc(1);
            if (b8.cpu_en) ones++;
            if (i == 8) step = 1'b0;
            if (i == 10) succ = 1'b0;
        end
        chk("run_len", ones, 10);
        chk("run_cnt", b8.step_cnt - c0, 10);
        chk("run_halted", 32'(b8.halted), 1);
        // address wrap and coincident presses
        sel = 0;
        press(0, 1, 0);
        chk("wrap_dec", 32'(b8.m_rf_addr), 32'hF);
        press(1, 0, 0);
        chk("wrap_inc", 32'(b8.m_rf_addr), 32'h0);
        press(1, 0, 0);
        press(1, 1, 0);
        chk("inc_dec_both", 32'(b8.m_rf_addr), 32'h1);
        // lock with sel!=0, then m_rf clear
        sel = 3;
        press(1, 0, 0);
        chk("sel_lock", 32'(b8.m_rf_addr), 32'h1);
        sel = 0;
        repeat (4) press(1, 0, 0);
        chk("addr5", 32'(b8.m_rf_addr), 32'h5);
        m_rf = 1'b1;
        cyc(5);
        chk("mrf_clear", 32'(b8.m_rf_addr), 32'h0);
        // scan of channel 2
        sel = 2;
        status[95:64] = 32'h1234ABCD;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (b8.an == 8'hFE && b8.seg == 7'h21) found = 1;
        end
        chk("scan_sync", found, 1);
        while (found == 1 && b8.an == 8'hFE) cyc(1);
        cyc(3 * 7);
        for (int d = 0; d < 8; d++) begin
            chk("scan_an", 32'(b8.an), 32'(8'(~(8'h01 << d))));
            chk("scan_seg", 32'(b8.seg), 32'(exp_seg[d]));
            cyc(3);
        end
        sel = 7;
        cyc(2);
        for (int i = 0; i < 24; i++) begin
            chk("oor_seg6", 32'(b6.seg), 32'h40);
            cyc(1);
        end
        // async reset in the middle of RUN
        sel = 0;
        press(1, 0, 0);
        succ = 1'b1;
        cyc(8);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_cpu_en", 32'(b8.cpu_en), 0);
        chk("arst_cnt", b8.step_cnt, 0);
        chk("arst_addr", 32'(b8.m_rf_addr), 0);
        chk("arst_an", 32'(b8.an), 32'hFF);
        succ = 1'b0;
        m_rf = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(3);
        chk("arst_halted", 32'(b8.halted), 1);
        // randomized phase
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5) == 0) step = ~step;
            if ($urandom_range(5) == 0) inc = ~inc;
            if ($urandom_range(5) == 0) dec = ~dec;
            if ($urandom_range(40) == 0) succ = ~succ;
            if ($urandom_range(60) == 0) m_rf = ~m_rf;
            if ($urandom_range(20) == 0) sel = $urandom_range(1) ? 3'($urandom_range(7)) : 3'd0;
            if ($urandom_range(30) == 0) status[32*$urandom_range(7) +: 32] = $urandom;
            mrf_data = $urandom;
            cyc(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
